// File: rtl/decode_issue_unit.sv
// decode_issue_unit: DEPTH-entry instruction queue between fetch and execute,
// a combinational MIPS32 decoder on the queue head, and a register scoreboard
// that holds issue while a source or destination register has a write in flight.
module decode_issue_unit #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [XLEN-1:0]          in_pc,
   input  logic                     flush,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_reg,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_pc_plus_4,
   output logic [31:0]              out_jump_addr,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_dst,
   output logic [31:0]              out_imm,
   output logic [4:0]               out_shamt,
   output logic [3:0]               out_alu_ctrl,
   output logic [1:0]               out_alu_src,
   output logic                     out_reg_write,
   output logic                     out_mem_read,
   output logic                     out_mem_write,
   output logic [3:0]               out_branch_type,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                          OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                          OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                          OP_LW    = 6'h23, OP_SW   = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                          FN_JR  = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21,
                          FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25,
                          FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                          FN_SLTU = 6'h2B;

   // Immediate extension: logical immediates zero-extend, everything else sign-extends.
   function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
      logic signed [15:0] simm;
      logic signed [31:0] sext;
      simm = imm;
      sext = 32'(simm);
      return zext ? {16'h0000, imm} : sext;
   endfunction

   // Queue storage holds data only; pointers and count carry the control state.
   logic [31:0]     inst_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREGS-1:0] busy_q, busy_d;

   logic            empty, full, push, pop, hazard, sb_set;
   logic [31:0]     head_inst;
   logic [XLEN-1:0] head_pc;
   logic [5:0]      opc, fn;

   logic [3:0]      dec_alu;
   logic [1:0]      dec_src;
   logic [4:0]      dec_dst;
   logic            dec_rw, dec_mr, dec_mw, dec_ill, dec_rs_used, dec_rt_used, dec_zext;
   logic [3:0]      dec_bt;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign in_ready  = !rst && !full;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   assign head_inst = inst_mem_q[rd_ptr_q];
   assign head_pc   = pc_mem_q[rd_ptr_q];
   assign opc       = head_inst[31:26];
   assign fn        = head_inst[5:0];
   assign count     = count_q;

   // Queue entry write on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_q] <= in_inst;
         pc_mem_q[wr_ptr_q]   <= in_pc;
      end
   end

   // Next pointer/count: flush empties the queue and drops a same-cycle push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         count_d  = count_q + CW'(push) - CW'(pop);
      end
   end

   // Queue control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Decode of the registered head entry; illegal encodings lose all side effects.
   always_comb begin
      dec_alu     = 4'b0000;
      dec_src     = 2'b00;
      dec_dst     = head_inst[20:16];
      dec_rw      = 1'b0;
      dec_mr      = 1'b0;
      dec_mw      = 1'b0;
      dec_bt      = 4'd0;
      dec_ill     = 1'b0;
      dec_rs_used = 1'b1;
      dec_rt_used = 1'b0;
      dec_zext    = 1'b0;
      case (opc)
         OP_RTYPE: begin
            dec_dst     = head_inst[15:11];
            dec_rw      = 1'b1;
            dec_rt_used = 1'b1;
            case (fn)
               FN_ADD, FN_ADDU: dec_alu = 4'b0000;
               FN_SUBU:         dec_alu = 4'b0001;
               FN_AND:          dec_alu = 4'b0010;
               FN_OR:           dec_alu = 4'b0011;
               FN_NOR:          dec_alu = 4'b0100;
               FN_XOR:          dec_alu = 4'b0101;
               FN_SLT:          dec_alu = 4'b1001;
               FN_SLTU:         dec_alu = 4'b1010;
               FN_SLL: begin dec_alu = 4'b0110; dec_src = 2'b01; dec_rs_used = 1'b0; end
               FN_SRA: begin dec_alu = 4'b0111; dec_src = 2'b01; dec_rs_used = 1'b0; end
               FN_SRL: begin dec_alu = 4'b1000; dec_src = 2'b01; dec_rs_used = 1'b0; end
               FN_JR: begin
                  dec_alu     = 4'b1110;
                  dec_rw      = 1'b0;
                  dec_rt_used = 1'b0;
                  dec_bt      = 4'd3;
               end
               default: dec_ill = 1'b1;
            endcase
            if (head_inst == 32'h0) dec_rw = 1'b0;
         end
         OP_J:     begin dec_dst = 5'd0; dec_bt = 4'd1; dec_rs_used = 1'b0; end
         OP_JAL:   begin dec_dst = 5'd31; dec_rw = 1'b1; dec_bt = 4'd2; dec_rs_used = 1'b0; end
         OP_BEQ:   begin dec_alu = 4'b0001; dec_bt = 4'd4; dec_rt_used = 1'b1; end
         OP_BNE:   begin dec_alu = 4'b0001; dec_bt = 4'd5; dec_rt_used = 1'b1; end
         OP_ADDIU: begin dec_alu = 4'b0000; dec_src = 2'b10; dec_rw = 1'b1; end
         OP_SLTI:  begin dec_alu = 4'b1001; dec_src = 2'b10; dec_rw = 1'b1; end
         OP_SLTIU: begin dec_alu = 4'b1010; dec_src = 2'b10; dec_rw = 1'b1; end
         OP_ANDI:  begin dec_alu = 4'b0010; dec_src = 2'b10; dec_rw = 1'b1; dec_zext = 1'b1; end
         OP_ORI:   begin dec_alu = 4'b0011; dec_src = 2'b10; dec_rw = 1'b1; dec_zext = 1'b1; end
         OP_XORI:  begin dec_alu = 4'b0101; dec_src = 2'b10; dec_rw = 1'b1; dec_zext = 1'b1; end
         OP_LUI:   begin dec_alu = 4'b1011; dec_src = 2'b10; dec_rw = 1'b1; dec_rs_used = 1'b0; end
         OP_LW:    begin dec_alu = 4'b0000; dec_src = 2'b10; dec_rw = 1'b1; dec_mr = 1'b1; end
         OP_SW:    begin dec_alu = 4'b0000; dec_src = 2'b11; dec_mw = 1'b1; dec_rt_used = 1'b1; end
         default:  dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_alu     = 4'b0000;
         dec_src     = 2'b00;
         dec_rw      = 1'b0;
         dec_mr      = 1'b0;
         dec_mw      = 1'b0;
         dec_bt      = 4'd0;
         dec_rs_used = 1'b0;
         dec_rt_used = 1'b0;
      end
   end

   // Hazard and issue: checked against the registered scoreboard only.
   always_comb begin
      hazard = !empty && ((dec_rs_used && busy_q[head_inst[25:21]]) ||
                          (dec_rt_used && busy_q[head_inst[20:16]]) ||
                          (dec_rw      && busy_q[dec_dst]));
      out_valid = !rst && !empty && !hazard && !flush;
   end

   // Output fields are forced to zero while the queue is empty.
   always_comb begin
      out_pc          = '0;
      out_pc_plus_4   = '0;
      out_jump_addr   = '0;
      out_rs          = '0;
      out_rt          = '0;
      out_dst         = '0;
      out_imm         = '0;
      out_shamt       = '0;
      out_alu_ctrl    = '0;
      out_alu_src     = '0;
      out_reg_write   = 1'b0;
      out_mem_read    = 1'b0;
      out_mem_write   = 1'b0;
      out_branch_type = '0;
      out_illegal     = 1'b0;
      if (!empty) begin
         out_pc          = head_pc;
         out_pc_plus_4   = head_pc + XLEN'(4);
         out_jump_addr   = {head_pc[31:28], head_inst[25:0], 2'b00};
         out_rs          = head_inst[25:21];
         out_rt          = head_inst[20:16];
         out_dst         = dec_dst;
         out_imm         = ext_imm(head_inst[15:0], dec_zext);
         out_shamt       = head_inst[10:6];
         out_alu_ctrl    = dec_alu;
         out_alu_src     = dec_src;
         out_reg_write   = dec_rw;
         out_mem_read    = dec_mr;
         out_mem_write   = dec_mw;
         out_branch_type = dec_bt;
         out_illegal     = dec_ill;
      end
   end

   // Scoreboard next state: writeback clears, issue sets, set wins on collision.
   assign sb_set = pop && dec_rw && (dec_dst != 5'd0);

   always_comb begin
      busy_d = busy_q;
      if (wb_valid) busy_d[wb_reg] = 1'b0;
      if (sb_set)   busy_d[dec_dst] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

endmodule

// File: tb/tb_decode_issue_unit.sv
// Bench for decode_issue_unit: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue/array reference model.
module tb_decode_issue_unit;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, out_pc_plus_4, out_jump_addr, out_imm;
   logic [4:0] wb_reg, out_rs, out_rt, out_dst, out_shamt;
   logic [3:0] out_alu_ctrl, out_branch_type;
   logic [1:0] out_alu_src;
   logic out_reg_write, out_mem_read, out_mem_write, out_illegal;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   decode_issue_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
      .wb_reg(wb_reg), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_jump_addr(out_jump_addr),
      .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_imm(out_imm),
      .out_shamt(out_shamt), .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch_type(out_branch_type),
      .out_illegal(out_illegal), .count(count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] pc, pc4, jaddr;
      logic [4:0]  rs, rt, dst;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [3:0]  alu;
      logic [1:0]  src;
      logic        rw, mr, mw;
      logic [3:0]  bt;
      logic        ill;
   } dec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   typedef enum {M_ADD, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                 M_SLL, M_SRL, M_SRA, M_JR, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI,
                 M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_ILL} mn_t;

   ent_t mq[$];
   bit   mbusy [32];

   function automatic mn_t mnem(input logic [31:0] w);
      if (w[31:26] == 6'h00) begin
         case (w[5:0])
            6'h20: return M_ADD;   6'h21: return M_ADDU;  6'h23: return M_SUBU;
            6'h24: return M_AND;   6'h25: return M_OR;    6'h26: return M_XOR;
            6'h27: return M_NOR;   6'h2A: return M_SLT;   6'h2B: return M_SLTU;
            6'h00: return M_SLL;   6'h02: return M_SRL;   6'h03: return M_SRA;
            6'h08: return M_JR;
            default: return M_ILL;
         endcase
      end
      case (w[31:26])
         6'h02: return M_J;      6'h03: return M_JAL;   6'h04: return M_BEQ;
         6'h05: return M_BNE;    6'h09: return M_ADDIU; 6'h0A: return M_SLTI;
         6'h0B: return M_SLTIU;  6'h0C: return M_ANDI;  6'h0D: return M_ORI;
         6'h0E: return M_XORI;   6'h0F: return M_LUI;   6'h23: return M_LW;
         6'h2B: return M_SW;
         default: return M_ILL;
      endcase
   endfunction

   function automatic bit uses_rs(input mn_t m);
      return !(m inside {M_J, M_JAL, M_LUI, M_SLL, M_SRL, M_SRA, M_ILL});
   endfunction

   function automatic bit uses_rt(input mn_t m);
      return m inside {M_ADD, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                       M_SLL, M_SRL, M_SRA, M_BEQ, M_BNE, M_SW};
   endfunction

   function automatic dec_t model_dec(input ent_t e);
      dec_t d;
      mn_t  m;
      m       = mnem(e.inst);
      d       = '0;
      d.pc    = e.pc;
      d.pc4   = e.pc + 32'd4;
      d.jaddr = {e.pc[31:28], e.inst[25:0], 2'b00};
      d.rs    = e.inst[25:21];
      d.rt    = e.inst[20:16];
      d.shamt = e.inst[10:6];
      d.imm   = (m inside {M_ANDI, M_ORI, M_XORI}) ? {16'h0, e.inst[15:0]}
                                                   : {{16{e.inst[15]}}, e.inst[15:0]};
      if (m == M_J)                d.dst = 5'd0;
      else if (m == M_JAL)         d.dst = 5'd31;
      else if (e.inst[31:26] == 0) d.dst = e.inst[15:11];
      else                         d.dst = e.inst[20:16];
      case (m)
         M_SUBU, M_BEQ, M_BNE: d.alu = 4'd1;
         M_AND, M_ANDI:        d.alu = 4'd2;
         M_OR, M_ORI:          d.alu = 4'd3;
         M_NOR:                d.alu = 4'd4;
         M_XOR, M_XORI:        d.alu = 4'd5;
         M_SLL:                d.alu = 4'd6;
         M_SRA:                d.alu = 4'd7;
         M_SRL:                d.alu = 4'd8;
         M_SLT, M_SLTI:        d.alu = 4'd9;
         M_SLTU, M_SLTIU:      d.alu = 4'd10;
         M_LUI:                d.alu = 4'd11;
         M_JR:                 d.alu = 4'd14;
         default:              d.alu = 4'd0;
      endcase
      if (m inside {M_SLL, M_SRL, M_SRA}) d.src = 2'b01;
      else if (m == M_SW) d.src = 2'b11;
      else if (m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW}) d.src = 2'b10;
      d.rw = ((m inside {M_ADD, M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                         M_SLL, M_SRL, M_SRA}) && e.inst != 0) ||
             (m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_JAL});
      d.mr  = (m == M_LW);
      d.mw  = (m == M_SW);
      d.bt  = (m == M_J) ? 4'd1 : (m == M_JAL) ? 4'd2 : (m == M_JR) ? 4'd3 :
              (m == M_BEQ) ? 4'd4 : (m == M_BNE) ? 4'd5 : 4'd0;
      d.ill = (m == M_ILL);
      return d;
   endfunction

   // Check all outputs against the model, then advance the model across one edge.
   task automatic tick();
      dec_t exp_d, act;
      bit   empty, hz, ev, er, pop, push;
      mn_t  m;
      empty = (mq.size() == 0);
      exp_d = '0;
      hz    = 0;
      if (!empty) begin
         exp_d = model_dec(mq[0]);
         m     = mnem(mq[0].inst);
         hz    = (uses_rs(m) && mbusy[exp_d.rs]) || (uses_rt(m) && mbusy[exp_d.rt]) ||
                 (exp_d.rw && mbusy[exp_d.dst]);
      end
      ev  = !rst && !empty && !hz && !flush;
      er  = !rst && (mq.size() < DEPTH);
      act = {out_pc, out_pc_plus_4, out_jump_addr, out_rs, out_rt, out_dst, out_imm,
             out_shamt, out_alu_ctrl, out_alu_src, out_reg_write, out_mem_read,
             out_mem_write, out_branch_type, out_illegal};
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, er);
      chk("count", count, mq.size());
      chk("fields", act, exp_d);
      pop  = ev && out_ready;
      push = in_valid && er && !flush;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         foreach (mbusy[i]) mbusy[i] = 0;
      end else begin
         if (wb_valid) mbusy[wb_reg] = 0;
         if (pop && exp_d.rw && exp_d.dst != 0) mbusy[exp_d.dst] = 1;
         if (flush) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{in_inst, in_pc});
         end
      end
      @(negedge clk);
   endtask

   task automatic set_in(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit fl = 0, input bit wbv = 0,
                         input logic [4:0] wbr = 0);
      in_valid  = iv;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      wb_valid  = wbv;
      wb_reg    = wbr;
      #1;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] f);
      return {6'h00, rs, rt, rd, sh, f};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [4:0] pick_reg();
      return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [5:0] rf [13];
      logic [5:0] io [11];
      int k;
      rf = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
             6'h00, 6'h02, 6'h03, 6'h08};
      io = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
      k  = $urandom_range(0, 29);
      if (k < 13) return rtype(pick_reg(), pick_reg(), pick_reg(), 5'($urandom), rf[k]);
      if (k < 24) return itype(io[k-13], pick_reg(), pick_reg(), 16'($urandom));
      if (k < 26) return {(k == 24) ? 6'h02 : 6'h03, 26'($urandom)};
      if (k < 28) return $urandom;
      return 32'h0;
   endfunction

   initial begin
      rst = 1'b1;
      in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; wb_valid = 0; wb_reg = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      set_in(0, 0, 0, 0);
      tick();
      rst = 1'b0;

      // Reset state and decode sweep
      set_in(1, 32'h2422FFFF, 32'h100, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_imm", out_imm, 0);
      tick();
      set_in(1, 32'h34038000, 32'h104, 0);
      chk("addiu_valid", out_valid, 1);
      chk("addiu_alu", out_alu_ctrl, 4'b0000);
      chk("addiu_src", out_alu_src, 2'b10);
      chk("addiu_dst", out_dst, 5'd2);
      chk("addiu_imm", out_imm, 32'hFFFFFFFF);
      tick();
      set_in(0, 0, 0, 1); tick();
      set_in(0, 0, 0, 1);
      chk("ori_imm", out_imm, 32'h00008000);
      chk("ori_dst", out_dst, 5'd3);
      tick();
      set_in(0, 0, 0, 1, 0, 1, 5'd2); tick();
      set_in(0, 0, 0, 1, 0, 1, 5'd3); tick();

      // RAW stall on a load destination
      set_in(1, 32'h8C250000, 32'h200, 1); tick();
      set_in(1, 32'h00A53021, 32'h204, 1);
      chk("lw_valid", out_valid, 1);
      chk("lw_memrd", out_mem_read, 1);
      tick();
      repeat (3) begin
         set_in(0, 0, 0, 1);
         chk("raw_stall", out_valid, 0);
         tick();
      end
      set_in(0, 0, 0, 1, 0, 1, 5'd5);
      chk("raw_stall_wb", out_valid, 0);
      tick();
      set_in(0, 0, 0, 1);
      chk("raw_release", out_valid, 1);
      chk("raw_dst", out_dst, 5'd6);
      tick();
      set_in(0, 0, 0, 1, 0, 1, 5'd6); tick();

      // Full queue with backpressure, then FIFO drain
      for (int i = 0; i < 4; i++) begin
         set_in(1, itype(6'h0D, 5'd0, 5'(8 + i), 16'(16 + i)), 32'h300 + 32'(4 * i), 0);
         tick();
      end
      set_in(1, itype(6'h0D, 5'd0, 5'd12, 16'h14), 32'h310, 0);
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      chk("full_head_imm", out_imm, 32'h10);
      tick();
      set_in(1, itype(6'h0D, 5'd0, 5'd12, 16'h14), 32'h310, 0);
      chk("hold_imm", out_imm, 32'h10);
      chk("hold_pc", out_pc, 32'h300);
      chk("hold_valid", out_valid, 1);
      tick();
      set_in(1, itype(6'h0D, 5'd0, 5'd12, 16'h14), 32'h310, 1);
      chk("full_pop_ready", in_ready, 0);
      tick();
      set_in(0, 0, 0, 1);
      chk("after_pop_ready", in_ready, 1);
      chk("order1", out_imm, 32'h11);
      tick();
      set_in(0, 0, 0, 1); chk("order2", out_imm, 32'h12); tick();
      set_in(0, 0, 0, 1); chk("order3", out_imm, 32'h13); tick();
      set_in(0, 0, 0, 1); chk("drained", count, 0); tick();

      // Flush with three queued and a simultaneous push; scoreboard survives
      set_in(1, rtype(5'd8, 5'd0, 5'd12, 5'd0, 6'h21), 32'h400, 0); tick();
      set_in(1, itype(6'h0D, 5'd0, 5'd14, 16'h1), 32'h404, 0); tick();
      set_in(1, itype(6'h0D, 5'd0, 5'd15, 16'h2), 32'h408, 0); tick();
      set_in(1, itype(6'h0D, 5'd0, 5'd16, 16'h3), 32'h40C, 1, 1);
      chk("flush_pre_count", count, 3);
      chk("flush_valid", out_valid, 0);
      tick();
      set_in(0, 0, 0, 1);
      chk("flush_count", count, 0);
      tick();
      set_in(1, rtype(5'd8, 5'd0, 5'd13, 5'd0, 6'h21), 32'h420, 1); tick();
      set_in(0, 0, 0, 1);
      chk("flush_busy_kept", out_valid, 0);
      chk("flush_busy_cnt", count, 1);
      tick();
      set_in(0, 0, 0, 1, 0, 1, 5'd8); tick();
      set_in(0, 0, 0, 1); chk("flush_release", out_valid, 1); tick();
      for (int r = 9; r <= 13; r++) begin
         set_in(0, 0, 0, 1, 0, 1, 5'(r)); tick();
      end

      // JAL then dependent JR
      set_in(1, 32'h0C100000, 32'h00400000, 1); tick();
      set_in(1, 32'h03E00008, 32'h00400004, 1);
      chk("jal_valid", out_valid, 1);
      chk("jal_bt", out_branch_type, 4'd2);
      chk("jal_dst", out_dst, 5'd31);
      chk("jal_jaddr", out_jump_addr, 32'h00400000);
      chk("jal_pc4", out_pc_plus_4, 32'h00400004);
      chk("jal_rw", out_reg_write, 1);
      tick();
      repeat (2) begin
         set_in(0, 0, 0, 1);
         chk("jr_stall", out_valid, 0);
         chk("jr_bt", out_branch_type, 4'd3);
         tick();
      end
      set_in(0, 0, 0, 1, 0, 1, 5'd31); tick();
      set_in(0, 0, 0, 1); chk("jr_release", out_valid, 1); tick();

      // Set/clear collision on the same register
      set_in(1, 32'h00223821, 32'h500, 1); tick();
      set_in(1, 32'h00E04021, 32'h504, 1, 0, 1, 5'd7);
      chk("coll_valid", out_valid, 1);
      tick();
      repeat (2) begin
         set_in(0, 0, 0, 1);
         chk("coll_busy", out_valid, 0);
         tick();
      end
      set_in(0, 0, 0, 1, 0, 1, 5'd7); tick();
      set_in(0, 0, 0, 1); chk("coll_release", out_valid, 1); tick();
      set_in(0, 0, 0, 1, 0, 1, 5'd8); tick();

      // Illegal opcode still issues with no side effects
      set_in(1, 32'hFC000000, 32'h600, 1); tick();
      set_in(0, 0, 0, 1);
      chk("ill_flag", out_illegal, 1);
      chk("ill_rw", out_reg_write, 0);
      chk("ill_valid", out_valid, 1);
      tick();

      // Randomized traffic including flushes, writebacks and mid-run resets
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         set_in($urandom_range(0, 9) < 7, gen_inst(), $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 3, pick_reg());
         tick();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_issue_unit.md
# decode_issue_unit

Parametrised decode stage for the MIPS32 pipeline. It replaces the single-register decode with a DEPTH-entry instruction queue, a combinational decoder on the queue head, and a register scoreboard that holds issue on RAW/WAW hazards. It sits between fetch and execute, with valid/ready handshakes on both sides, and frees execute from its own stall bookkeeping.

## Interface

Parameters:
- DEPTH, 4, instruction queue entries; power of two, at least 2
- XLEN, 32, PC width
- NREGS, 32, architectural registers tracked by the scoreboard; register index width is $clog2(NREGS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; equals !full, and is 0 while rst is high
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- flush  in  1  discard all queued instructions
- wb_valid  in  1  writeback retires a register write
- wb_reg  in  5  register written back
- out_valid  out  1  head decoded and hazard-free
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  head PC
- out_pc_plus_4  out  XLEN  out_pc + 4, modulo 2^XLEN
- out_jump_addr  out  32  {out_pc[31:28], inst[25:0], 2'b0}
- out_rs, out_rt, out_dst  out  5  source indices and destination index
- out_imm  out  32  extended immediate
- out_shamt  out  5  inst[10:6]
- out_alu_ctrl  out  4  ALU operation
- out_alu_src  out  2  00 reg, 01 shamt, 10 imm, 11 store-imm
- out_reg_write, out_mem_read, out_mem_write  out  1  control
- out_branch_type  out  4  0 none, 1 J, 2 JAL, 3 JR, 4 BEQ, 5 BNE
- out_illegal  out  1  unsupported opcode or funct
- count  out  $clog2(DEPTH)+1  queue occupancy

## Operation

- Push: an instruction is written when in_valid && in_ready && !flush.
- Pop: the head is removed when out_valid && out_ready.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- ALU codes:
  - add/addu/addiu/lw/sw: 0000
  - subu/beq/bne: 0001
  - and/andi: 0010
  - or/ori: 0011
  - nor: 0100
  - xor/xori: 0101
  - sll: 0110
  - sra: 0111
  - srl: 1000
  - slt/slti: 1001
  - sltu/sltiu: 1010
  - lui: 1011
  - jr: 1110
  - j/jal: 0000
- Immediates: andi, ori and xori zero-extend inst[15:0]; all other opcodes sign-extend.
- Destination:
  - R-type: rd.
  - I-type: rt.
  - JAL: 31, with reg_write=1.
  - Branches, J, JR and SW: reg_write=0.
- inst==0 (NOP) decodes with reg_write=0.
- Illegal opcode or funct: out_illegal=1 with all write, mem and branch controls 0. It still issues normally.
- Source use:
  - rs is used except for J, JAL, LUI, SLL, SRL and SRA.
  - rt is used for R-type except JR, and for BEQ, BNE and SW.
- Scoreboard: busy[NREGS]. Bit 0 is never set.
  - Issue with reg_write and dst!=0 sets busy[dst].
  - wb_valid clears busy[wb_reg].
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: the queue is non-empty and busy is set for a used rs, a used rt, or a written dst. A hazard forces out_valid=0.
- Flush: count goes to 0 the next cycle. Any push in that cycle is dropped, and no issue occurs. The scoreboard is unchanged.

## Timing

- Reset values:
  - count=0, busy all 0, out_valid=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after.
  - All out_* data fields are 0 while empty.
- Latency: a pushed instruction can be presented with out_valid=1 in the cycle after the push, at the earliest. There is no bypass from the input to the output.
- The decode is combinational from the registered head entry. While out_valid=1 and out_ready=0, all out_* fields hold stable.
- out_valid falls without a pop only on flush or rst.
- The hazard check uses the registered scoreboard. A wb_valid clear releases a stalled head in the following cycle.
- in_ready depends only on count, with no combinational path from out_ready. A full queue therefore does not accept a push in the same cycle it pops.
- rst mid-operation: the queue and scoreboard clear on the next edge, and the queue contents are lost.

## Test plan

- Decode sweep:
  - Push addiu $2,$1,-1 (0x2422FFFF). Require alu_ctrl=0000, alu_src=10, dst=2, imm=0xFFFFFFFF.
  - Push ori $3,$0,0x8000. Require imm=0x00008000.
- RAW stall:
  - Issue lw $5,0($1), then push addu $6,$5,$5.
  - Require out_valid=0 until wb_valid with wb_reg=5, then out_valid=1 one cycle later.
- Full/backpressure:
  - Hold out_ready=0 and push 4 instructions with DEPTH=4.
  - Require count=4, in_ready=0, and the head fields stable.
  - Then raise out_ready. Require in_ready=1 the next cycle and FIFO order preserved.
- Flush:
  - With 3 queued, assert flush with in_valid=1.
  - Require count=0 next cycle, the pushed instruction dropped, and busy unchanged.
- JAL/JR: in_pc=0x00400000, jal 0x0100000.
  - Require branch_type=2, dst=31, jump_addr=0x00400000, pc_plus_4=0x00400004.
  - A following jr $31 stalls until wb of register 31.
- Set/clear collision:
  - Issue addu $7 in the same cycle as wb_valid with wb_reg=7.
  - Require busy[7]=1 afterwards.
